gate_arbiter: RTL
=================

GATE_ARBITER -- requirements
Module: gate_arbiter

Interface
REQ-001 The block SHALL have exactly one clock, clk, and one reset, rst_n, which is asynchronous and active-low.
REQ-002 Port clk, input, 1 bit: rising-edge clock for all state.
REQ-003 Port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-004 Port req, input, 4 bits: req[i]=1 means requester i asks for the shared gate unit.
REQ-005 Port a, input, 4 bits: a[i] is the first operand of requester i.
REQ-006 Port b, input, 4 bits: b[i] is the second operand of requester i.
REQ-007 Port op, input, 8 bits: op[2i+1:2i] is the gate select of requester i.
REQ-008 Port gnt, output, 4 bits: one-hot grant, registered.
REQ-009 Port y, output, 1 bit: registered result of the shared gate unit.
REQ-010 Port y_valid, output, 1 bit: one-cycle pulse marking y and y_id valid.
REQ-011 Port y_id, output, 2 bits: index of the requester that owns the current y.
REQ-012 Port done_cnt, output, 8 bits: count of completed operations.

Function
REQ-013 The gate select SHALL be decoded as 00 NOR ~(a|b), 01 NAND ~(a&b), 10 XOR, 11 XNOR.
REQ-014 The block SHALL contain a single shared gate unit, driven only from latched operands a_q, b_q and op_q.
REQ-015 The FSM SHALL have exactly two states, IDLE and EXEC.
REQ-016 IDLE with req==0: the FSM SHALL remain in IDLE, with gnt=0 and y_valid=0 on the next cycle.
REQ-017 IDLE with req!=0: the winner SHALL be the first set bit of req, scanning upward from rr_ptr modulo 4.
REQ-018 On that same edge the block SHALL set gnt to one-hot(winner), latch a[w], b[w], op[w] and id_q=w, and go to EXEC.
REQ-019 gnt SHALL be high for exactly the one EXEC cycle and 0 in all other cycles.
REQ-020 EXEC: on the next edge the block SHALL register y=f(op_q,a_q,b_q), y_valid=1, y_id=id_q, rr_ptr=(id_q+1) mod 4, done_cnt+1, and go to IDLE.
REQ-021 Latency SHALL be one cycle from req sampled in IDLE to gnt, and two cycles from req to y_valid.
REQ-022 Maximum throughput SHALL be one operation per 2 cycles.
REQ-023 y and y_id SHALL hold their last value when y_valid=0.
REQ-024 Only the operand and select values sampled at the grant edge SHALL matter; input changes during EXEC SHALL not affect y.
REQ-025 req SHALL be ignored during EXEC; new requests are arbitrated at the next IDLE cycle.
REQ-026 A requester holding req high after its grant SHALL be re-arbitrated with lowest priority, because rr_ptr has advanced past it.
REQ-027 rr_ptr SHALL wrap from 3 to 0.
REQ-028 done_cnt SHALL wrap from 255 to 0 without saturation or a flag.
REQ-029 Requests arriving while a grant is pending SHALL not be lost, provided req is held high.

Reset
REQ-030 While rst_n=0 the block SHALL force: state=IDLE, gnt=0, y=0, y_valid=0, y_id=0, done_cnt=0, rr_ptr=0, a_q=b_q=0, op_q=0, id_q=0.
REQ-031 Reset asserted during EXEC SHALL abort the operation: no y_valid pulse and no done_cnt increment.
REQ-032 After rst_n deasserts, the first arbitration SHALL start at the first rising edge with rst_n=1.

Verification
REQ-033 Single request: req=0001, a[0]=0, b[0]=0, op=00 (NOR) -> gnt=0001 next cycle; then y=1, y_valid=1, y_id=0, done_cnt=1.
REQ-034 All four ops for requester 2 with (a,b)=(1,0) -> NOR=0, NAND=1, XOR=1, XNOR=0, each with y_id=2.
REQ-035 Fairness: req=1111 held high -> grant order 0,1,2,3,0,...; y_valid on every second cycle.
REQ-036 Wrap priority: after serving requester 3, req=1001 -> requester 0 granted before requester 3.
REQ-037 Mid-operation reset: pulse rst_n low during EXEC -> no y_valid pulse, all outputs 0, done_cnt=0.
REQ-038 Counter wrap: 256 completed operations -> done_cnt reads 0 after the 256th y_valid pulse.

Source files
------------

// File: rtl/gate_arbiter.sv
// rtl/gate_arbiter.sv - round-robin arbiter in front of one shared 2-input gate unit
// Each grant takes two cycles: IDLE picks and latches a requester, EXEC evaluates and retires it.
module gate_arbiter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic [7:0] op,
  output logic [3:0] gnt,
  output logic       y,
  output logic       y_valid,
  output logic [1:0] y_id,
  output logic [7:0] done_cnt
);

  typedef enum logic {IDLE, EXEC} state_t;

  state_t     state, state_d;
  logic [1:0] rr_ptr, rr_ptr_d;
  logic [1:0] id_q, id_d;
  logic [1:0] op_q, op_d;
  logic       a_q, a_d, b_q, b_d;
  logic [3:0] gnt_d;
  logic       y_d, y_valid_d;
  logic [1:0] y_id_d;
  logic [7:0] done_cnt_d;
  logic [1:0] win, idx;
  logic       found;
  logic       gate_out;

  // First requester at or above rr_ptr, wrapping modulo 4.
  always_comb begin
    win   = rr_ptr;
    idx   = rr_ptr;
    found = 1'b0;
    for (int k = 0; k < 4; k++) begin
      idx = rr_ptr + 2'(k);
      if (!found && req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    case (op_q)
      2'b00:   gate_out = ~(a_q | b_q);
      2'b01:   gate_out = ~(a_q & b_q);
      2'b10:   gate_out = a_q ^ b_q;
      default: gate_out = ~(a_q ^ b_q);
    endcase
  end

  always_comb begin
    state_d    = state;
    rr_ptr_d   = rr_ptr;
    id_d       = id_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    gnt_d      = 4'b0000;
    y_d        = y;
    y_valid_d  = 1'b0;
    y_id_d     = y_id;
    done_cnt_d = done_cnt;
    case (state)
      IDLE: begin
        if (found) begin
          gnt_d   = 4'b0001 << win;
          a_d     = a[win];
          b_d     = b[win];
          op_d    = op[{win, 1'b0} +: 2];
          id_d    = win;
          state_d = EXEC;
        end
      end
      default: begin
        y_d        = gate_out;
        y_valid_d  = 1'b1;
        y_id_d     = id_q;
        rr_ptr_d   = id_q + 2'd1;
        done_cnt_d = done_cnt + 8'd1;
        state_d    = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      rr_ptr   <= 2'd0;
      id_q     <= 2'd0;
      op_q     <= 2'd0;
      a_q      <= 1'b0;
      b_q      <= 1'b0;
      gnt      <= 4'b0000;
      y        <= 1'b0;
      y_valid  <= 1'b0;
      y_id     <= 2'd0;
      done_cnt <= 8'd0;
    end else begin
      state    <= state_d;
      rr_ptr   <= rr_ptr_d;
      id_q     <= id_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      gnt      <= gnt_d;
      y        <= y_d;
      y_valid  <= y_valid_d;
      y_id     <= y_id_d;
      done_cnt <= done_cnt_d;
    end
  end

endmodule
